// File: rtl/chess_pkg.sv
`default_nettype none
// ==========================================================================
// chess_pkg : board encoding, square type, start position and FSM states
// Rev 1.0
// ==========================================================================
package chess_pkg;

  typedef logic [4:0] piece_t;

  localparam int OCC_BIT   = 0;
  localparam int COLOR_BIT = 1;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  localparam logic [2:0] TYPE_NONE   = 3'b000;
  localparam logic [2:0] TYPE_PAWN   = 3'b001;
  localparam logic [2:0] TYPE_KNIGHT = 3'b010;
  localparam logic [2:0] TYPE_BISHOP = 3'b011;
  localparam logic [2:0] TYPE_ROOK   = 3'b100;
  localparam logic [2:0] TYPE_QUEEN  = 3'b101;
  localparam logic [2:0] TYPE_KING   = 3'b110;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
  } sq_t;

  // Element index is {row,col}; the literal runs from square 63 down to square 0.
  localparam logic [63:0][4:0] START_POS = {
    5'b10001, 5'b01001, 5'b01101, 5'b11001, 5'b10101, 5'b01101, 5'b01001, 5'b10001,
    {8{5'b00101}},
    {32{5'b00000}},
    {8{5'b00111}},
    5'b10011, 5'b01011, 5'b01111, 5'b11011, 5'b10111, 5'b01111, 5'b01011, 5'b10011
  };

  typedef enum logic [1:0] {
    ST_SRC    = 2'd0,
    ST_DST    = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  function automatic logic promotes(input piece_t p, input logic [2:0] dst_row);
    return p[OCC_BIT] && (p[4:2] == TYPE_PAWN) &&
           (((p[COLOR_BIT] == WHITE) && (dst_row == 3'd0)) ||
            ((p[COLOR_BIT] == BLACK) && (dst_row == 3'd7)));
  endfunction

  function automatic piece_t as_queen(input piece_t p);
    return {TYPE_QUEEN, p[COLOR_BIT], 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/board_regfile.sv
`default_nettype none
// ==========================================================================
// board_regfile : 64 x 5-bit board store, two async reads, one move write
// Rev 1.0
// ==========================================================================
module board_regfile
  import chess_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] vga_addr,
  output piece_t     vga_piece,
  input  logic [5:0] fsm_addr,
  output piece_t     fsm_piece,
  input  logic       wr_en,
  input  logic [5:0] wr_src,
  input  logic [5:0] wr_dst,
  input  piece_t     wr_data
);

  logic [63:0][4:0] board_q;
  logic [63:0][4:0] board_d;

  // Destination written after the source clear so it wins if they ever alias.
  always_comb begin
    board_d = board_q;
    if (wr_en) begin
      board_d[wr_src] = 5'b00000;
      board_d[wr_dst] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      board_q <= START_POS;
    end else begin
      board_q <= board_d;
    end
  end

  assign vga_piece = board_q[vga_addr];
  assign fsm_piece = board_q[fsm_addr];

endmodule
`default_nettype wire

// File: rtl/move_controller.sv
`default_nettype none
// ==========================================================================
// move_controller : select/check/commit sequencer owning the chess board
// Rev 1.0
// ==========================================================================
module move_controller
  import chess_pkg::*;
#(
  parameter int CHK_TIMEOUT = 16,
  parameter bit PROMOTE_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] cursor_row,
  input  logic [2:0] cursor_col,
  input  logic       select,
  input  logic       cancel,
  output logic       chk_req,
  output logic [5:0] chk_src,
  output logic [5:0] chk_dst,
  input  logic       chk_ack,
  input  logic       chk_legal,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output logic [4:0] rd_piece,
  output logic       turn,
  output logic       sel_valid,
  output logic [5:0] sel_src,
  output logic       move_done,
  output logic       move_reject,
  output logic [4:0] captured
);

  localparam int                CNT_W    = $clog2(CHK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CHK_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              turn_q, turn_d;
  logic              sel_valid_q, sel_valid_d;
  sq_t               sel_src_q, sel_src_d;
  piece_t            src_piece_q, src_piece_d;
  sq_t               dst_q, dst_d;
  logic              chk_req_q, chk_req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              move_done_q, move_done_d;
  logic              move_reject_q, move_reject_d;
  piece_t            captured_q, captured_d;

  sq_t    cur_sq;
  sq_t    fsm_addr;
  piece_t fsm_piece;
  piece_t vga_piece;
  piece_t wr_data;
  logic   wr_en;
  logic   own_piece;

  assign cur_sq    = {cursor_row, cursor_col};
  // During COMMIT the FSM port looks at the destination to capture what was there.
  assign fsm_addr  = (state_q == ST_COMMIT) ? dst_q : cur_sq;
  assign own_piece = fsm_piece[OCC_BIT] && (fsm_piece[COLOR_BIT] == turn_q);
  assign wr_data   = (PROMOTE_EN && promotes(src_piece_q, dst_q.row)) ?
                     as_queen(src_piece_q) : src_piece_q;

  board_regfile u_board (
    .clk       (clk),
    .reset     (reset),
    .vga_addr  ({rd_row, rd_col}),
    .vga_piece (vga_piece),
    .fsm_addr  (fsm_addr),
    .fsm_piece (fsm_piece),
    .wr_en     (wr_en),
    .wr_src    (sel_src_q),
    .wr_dst    (dst_q),
    .wr_data   (wr_data)
  );

  always_comb begin
    state_d       = state_q;
    turn_d        = turn_q;
    sel_valid_d   = sel_valid_q;
    sel_src_d     = sel_src_q;
    src_piece_d   = src_piece_q;
    dst_d         = dst_q;
    chk_req_d     = chk_req_q;
    cnt_d         = cnt_q;
    move_done_d   = 1'b0;
    move_reject_d = 1'b0;
    captured_d    = captured_q;
    wr_en         = 1'b0;

    case (state_q)
      ST_SRC: begin
        if (select && !cancel) begin
          if (own_piece) begin
            sel_src_d   = cur_sq;
            src_piece_d = fsm_piece;
            sel_valid_d = 1'b1;
            state_d     = ST_DST;
          end else begin
            move_reject_d = 1'b1;
          end
        end
      end

      ST_DST: begin
        if (cancel) begin
          sel_valid_d = 1'b0;
          state_d     = ST_SRC;
        end else if (select) begin
          if (cur_sq == sel_src_q) begin
            sel_valid_d = 1'b0;
            state_d     = ST_SRC;
          end else if (own_piece) begin
            sel_src_d   = cur_sq;
            src_piece_d = fsm_piece;
          end else begin
            dst_d     = cur_sq;
            chk_req_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        if (cancel) begin
          chk_req_d   = 1'b0;
          cnt_d       = '0;
          sel_valid_d = 1'b0;
          state_d     = ST_SRC;
        end else if (chk_ack) begin
          chk_req_d = 1'b0;
          cnt_d     = '0;
          if (chk_legal) begin
            state_d = ST_COMMIT;
          end else begin
            move_reject_d = 1'b1;
            state_d       = ST_DST;
          end
        end else if (cnt_q == CNT_LAST) begin
          chk_req_d     = 1'b0;
          cnt_d         = '0;
          move_reject_d = 1'b1;
          state_d       = ST_DST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_COMMIT: begin
        wr_en       = 1'b1;
        captured_d  = fsm_piece;
        turn_d      = ~turn_q;
        move_done_d = 1'b1;
        sel_valid_d = 1'b0;
        state_d     = ST_SRC;
      end

      default: begin
        state_d = ST_SRC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_SRC;
      turn_q        <= 1'b0;
      sel_valid_q   <= 1'b0;
      sel_src_q     <= '0;
      src_piece_q   <= '0;
      dst_q         <= '0;
      chk_req_q     <= 1'b0;
      cnt_q         <= '0;
      move_done_q   <= 1'b0;
      move_reject_q <= 1'b0;
      captured_q    <= '0;
    end else begin
      state_q       <= state_d;
      turn_q        <= turn_d;
      sel_valid_q   <= sel_valid_d;
      sel_src_q     <= sel_src_d;
      src_piece_q   <= src_piece_d;
      dst_q         <= dst_d;
      chk_req_q     <= chk_req_d;
      cnt_q         <= cnt_d;
      move_done_q   <= move_done_d;
      move_reject_q <= move_reject_d;
      captured_q    <= captured_d;
    end
  end

  assign chk_req     = chk_req_q;
  assign chk_src     = sel_src_q;
  assign chk_dst     = dst_q;
  assign rd_piece    = vga_piece;
  assign turn        = turn_q;
  assign sel_valid   = sel_valid_q;
  assign sel_src     = sel_src_q;
  assign move_done   = move_done_q;
  assign move_reject = move_reject_q;
  assign captured    = captured_q;

endmodule
`default_nettype wire

// File: tb/tb_move_controller.sv
`default_nettype none
// ==========================================================================
// tb_move_controller : directed scoreboard bench for move_controller
// Rev 1.0
// ==========================================================================
module tb_move_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] cursor_row, cursor_col;
  logic       select, cancel;
  logic       chk_req;
  logic [5:0] chk_src, chk_dst;
  logic       chk_ack, chk_legal;
  logic [2:0] rd_row, rd_col;
  logic [4:0] rd_piece;
  logic       turn, sel_valid;
  logic [5:0] sel_src;
  logic       move_done, move_reject;
  logic [4:0] captured;

  always #5 clk = ~clk;

  move_controller #(.CHK_TIMEOUT(16), .PROMOTE_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .select(select), .cancel(cancel), .chk_req(chk_req), .chk_src(chk_src),
    .chk_dst(chk_dst), .chk_ack(chk_ack), .chk_legal(chk_legal),
    .rd_row(rd_row), .rd_col(rd_col), .rd_piece(rd_piece), .turn(turn),
    .sel_valid(sel_valid), .sel_src(sel_src), .move_done(move_done),
    .move_reject(move_reject), .captured(captured)
  );

  typedef struct {
    bit         done;
    logic [4:0] cap;
  } exp_t;

  exp_t       sb[$];
  logic [4:0] model [64];
  logic       model_turn;
  int         n_assert = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int r, input int c);
    cursor_row = 3'(r);
    cursor_col = 3'(c);
    select     = 1'b1;
    tick();
    select     = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic read_sq(input int r, input int c, output logic [4:0] p);
    rd_row = 3'(r);
    rd_col = 3'(c);
    #1;
    p = rd_piece;
  endtask

  task automatic check_sq(input string tag, input int r, input int c);
    logic [4:0] p;
    read_sq(r, c, p);
    check(tag, {27'd0, p}, {27'd0, model[r*8+c]});
  endtask

  // Waits (bounded) for a done/reject pulse and compares it to the scoreboard head.
  task automatic wait_event(input string tag, output int n);
    exp_t e;
    n = 0;
    while (!(move_done || move_reject) && n < 40) begin
      tick();
      n++;
    end
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s observed=event expected=no_pending_entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".done"}, {31'd0, move_done}, {31'd0, e.done});
      check({tag, ".reject"}, {31'd0, move_reject}, {31'd0, !e.done});
      if (e.done) check({tag, ".captured"}, {27'd0, captured}, {27'd0, e.cap});
    end
  endtask

  task automatic do_move(input int sr, input int sc, input int dr, input int dc,
                         input bit legal, input string tag);
    exp_t       e;
    logic [4:0] p;
    int         n;
    press(sr, sc);
    check({tag, ".sel_valid"}, {31'd0, sel_valid}, 32'd1);
    check({tag, ".sel_src"}, {26'd0, sel_src}, 32'(sr * 8 + sc));
    press(dr, dc);
    check({tag, ".chk_req"}, {31'd0, chk_req}, 32'd1);
    check({tag, ".chk_src"}, {26'd0, chk_src}, 32'(sr * 8 + sc));
    check({tag, ".chk_dst"}, {26'd0, chk_dst}, 32'(dr * 8 + dc));
    tick();
    tick();
    check({tag, ".chk_req_held"}, {31'd0, chk_req}, 32'd1);
    e.done = legal;
    e.cap  = model[dr*8+dc];
    sb.push_back(e);
    chk_ack   = 1'b1;
    chk_legal = legal;
    tick();
    chk_ack   = 1'b0;
    chk_legal = 1'b0;
    check({tag, ".chk_req_drop"}, {31'd0, chk_req}, 32'd0);
    if (legal) begin
      check({tag, ".done_early"}, {31'd0, move_done}, 32'd0);
      tick();
    end
    wait_event(tag, n);
    check({tag, ".latency"}, n, 32'd0);
    if (legal) begin
      p = model[sr*8+sc];
      if (p[4:2] == 3'b001 && ((p[1] == 1'b0 && dr == 0) || (p[1] == 1'b1 && dr == 7)))
        p = {3'b101, p[1], 1'b1};
      model[dr*8+dc] = p;
      model[sr*8+sc] = 5'b00000;
      model_turn     = ~model_turn;
      check_sq({tag, ".src_sq"}, sr, sc);
      check_sq({tag, ".dst_sq"}, dr, dc);
      check({tag, ".turn"}, {31'd0, turn}, {31'd0, model_turn});
      check({tag, ".sel_cleared"}, {31'd0, sel_valid}, 32'd0);
    end else begin
      check({tag, ".src_kept"}, {31'd0, sel_valid}, 32'd1);
    end
  endtask

  task automatic init_model();
    logic [39:0] r0, r7;
    r0 = {5'b10011, 5'b01011, 5'b01111, 5'b10111, 5'b11011, 5'b01111, 5'b01011, 5'b10011};
    r7 = {5'b10001, 5'b01001, 5'b01101, 5'b10101, 5'b11001, 5'b01101, 5'b01001, 5'b10001};
    for (int i = 0; i < 64; i++) model[i] = 5'b00000;
    for (int c = 0; c < 8; c++) begin
      model[c]      = r0[39-5*c -: 5];
      model[56 + c] = r7[39-5*c -: 5];
      model[8 + c]  = 5'b00111;
      model[48 + c] = 5'b00101;
    end
    model_turn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    logic [4:0] p;

    reset = 1'b1; select = 1'b0; cancel = 1'b0; chk_ack = 1'b0; chk_legal = 1'b0;
    cursor_row = '0; cursor_col = '0; rd_row = '0; rd_col = '0;
    init_model();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst.turn", {31'd0, turn}, 32'd0);
    check("rst.sel_valid", {31'd0, sel_valid}, 32'd0);
    check("rst.sel_src", {26'd0, sel_src}, 32'd0);
    check("rst.chk_req", {31'd0, chk_req}, 32'd0);
    check("rst.move_done", {31'd0, move_done}, 32'd0);
    check("rst.move_reject", {31'd0, move_reject}, 32'd0);
    check("rst.captured", {27'd0, captured}, 32'd0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        check_sq($sformatf("rst.board_%0d_%0d", r, c), r, c);

    // Wrong colour and empty squares are refused in SRC.
    e.done = 1'b0; e.cap = 5'b0;
    sb.push_back(e);
    press(1, 0);
    wait_event("src_black_pawn", n);
    check("src_black_pawn.lat", n, 32'd0);
    check("src_black_pawn.sel_valid", {31'd0, sel_valid}, 32'd0);
    sb.push_back(e);
    press(4, 4);
    wait_event("src_empty", n);
    check("src_empty.sel_valid", {31'd0, sel_valid}, 32'd0);

    // Deselect by reselecting the source, then re-latch onto another own piece.
    press(6, 4);
    press(6, 4);
    check("deselect.sel_valid", {31'd0, sel_valid}, 32'd0);
    check("deselect.no_reject", {31'd0, move_reject}, 32'd0);
    press(6, 3);
    press(6, 4);
    check("relatch.sel_src", {26'd0, sel_src}, 32'(6 * 8 + 4));
    check("relatch.sel_valid", {31'd0, sel_valid}, 32'd1);
    do_cancel();
    check("dst_cancel.sel_valid", {31'd0, sel_valid}, 32'd0);

    do_move(6, 4, 4, 4, 1'b1, "e2e4");
    do_move(1, 7, 2, 7, 1'b1, "black_h");

    // Checker silence: refused after the timeout, source kept in DST.
    press(7, 1);
    press(5, 2);
    check("tmo.chk_req", {31'd0, chk_req}, 32'd1);
    sb.push_back(e);
    wait_event("tmo", n);
    check("tmo.cycles", n, 32'd16);
    check("tmo.sel_valid", {31'd0, sel_valid}, 32'd1);
    check("tmo.sel_src", {26'd0, sel_src}, 32'(7 * 8 + 1));
    check("tmo.chk_req_drop", {31'd0, chk_req}, 32'd0);
    press(5, 2);
    check("tmo.still_dst", {31'd0, chk_req}, 32'd1);
    do_cancel();
    check("check_cancel.chk_req", {31'd0, chk_req}, 32'd0);
    check("check_cancel.sel_valid", {31'd0, sel_valid}, 32'd0);

    // Cancel beats a simultaneous legal ack.
    press(6, 0);
    press(1, 0);
    check("cx_ack.chk_req", {31'd0, chk_req}, 32'd1);
    cancel = 1'b1; chk_ack = 1'b1; chk_legal = 1'b1;
    tick();
    cancel = 1'b0; chk_ack = 1'b0; chk_legal = 1'b0;
    check("cx_ack.chk_req_drop", {31'd0, chk_req}, 32'd0);
    check("cx_ack.sel_valid", {31'd0, sel_valid}, 32'd0);
    tick();
    check("cx_ack.no_done", {31'd0, move_done}, 32'd0);
    check_sq("cx_ack.src_sq", 6, 0);
    check_sq("cx_ack.dst_sq", 1, 0);
    check("cx_ack.turn", {31'd0, turn}, 32'd0);
    sb.push_back(e);
    press(1, 0);
    wait_event("cx_ack.in_src", n);
    check("cx_ack.in_src_lat", n, 32'd0);

    do_move(6, 0, 1, 0, 1'b0, "illegal");
    do_cancel();
    do_move(6, 0, 1, 0, 1'b1, "pawn_takes_pawn");
    do_move(1, 1, 2, 1, 1'b1, "black_b");
    do_move(1, 0, 0, 0, 1'b1, "promote");
    read_sq(0, 0, p);
    check("promote.queen", {27'd0, p}, 32'h15);
    check("promote.captured_rook", {27'd0, captured}, 32'h13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
